// File: rtl/ui_to_tilelink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ui_to_tilelink
// Brief    : MIG-style UI slave port bridged onto a 32-bit TileLink-UL master.
//            A read becomes one 16-byte Get. A write becomes four Put beats.
//            Only one transaction is in flight at a time.
// Revision : 1.0  initial release
// ============================================================================
module ui_to_tilelink #(
   parameter int TL_RS     = 4,
   parameter int SOURCE_ID = 0
) (
   input  logic               tilelink_clock_i,
   input  logic               tilelink_reset_i,
   // UI slave port
   input  logic [2:0]         app_cmd,
   input  logic [27:0]        app_addr,
   input  logic               app_en,
   output logic               app_rdy,
   input  logic [127:0]       app_wdf_data,
   input  logic [15:0]        app_wdf_mask,
   input  logic               app_wdf_wren,
   input  logic               app_wdf_end,
   output logic               app_wdf_rdy,
   output logic [127:0]       app_rd_data,
   output logic               app_rd_data_valid,
   output logic               app_rd_data_end,
   // TileLink A channel
   output logic [2:0]         tl_a_opcode,
   output logic [2:0]         tl_a_param,
   output logic [3:0]         tl_a_size,
   output logic [TL_RS-1:0]   tl_a_source,
   output logic [27:0]        tl_a_address,
   output logic [3:0]         tl_a_mask,
   output logic [31:0]        tl_a_data,
   output logic               tl_a_corrupt,
   output logic               tl_a_valid,
   input  logic               tl_a_ready,
   // TileLink D channel
   input  logic [2:0]         tl_d_opcode,
   input  logic [1:0]         tl_d_param,
   input  logic [3:0]         tl_d_size,
   input  logic [TL_RS-1:0]   tl_d_source,
   input  logic               tl_d_denied,
   input  logic [31:0]        tl_d_data,
   input  logic               tl_d_corrupt,
   input  logic               tl_d_valid,
   output logic               tl_d_ready,
   output logic               bridge_error_o
);

   localparam logic [2:0]       c_OP_GET      = 3'd4;
   localparam logic [2:0]       c_OP_PUT_FULL = 3'd0;
   localparam logic [2:0]       c_OP_PUT_PART = 3'd1;
   localparam logic [3:0]       c_SIZE_16B    = 4'd4;
   localparam logic [TL_RS-1:0] c_SRC         = TL_RS'(SOURCE_ID);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_RESP = 3'd2,
      S_WR_WAIT = 3'd3,
      S_WR_BEAT = 3'd4,
      S_WR_RESP = 3'd5
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [1:0]     r_beat, w_beat_nxt, w_beat_inc;
   logic           r_err, w_err_nxt;
   logic [95:0]    r_rd_buf, w_rd_buf_nxt;

   // single-entry write-data buffer
   logic           r_buf_full;
   logic [127:0]   r_wdf_data;
   logic [15:0]    r_wdf_mask;
   logic           w_buf_fill, w_buf_free;
   logic [127:0]   w_wdf_data;
   logic [15:0]    w_wdf_mask;

   // next values of the registered outputs
   logic           w_a_valid_n;
   logic [2:0]     w_a_opcode_n;
   logic [3:0]     w_a_size_n;
   logic [TL_RS-1:0] w_a_source_n;
   logic [27:0]    w_a_addr_n;
   logic [3:0]     w_a_mask_n;
   logic [31:0]    w_a_data_n;
   logic [127:0]   w_rd_data_n;
   logic           w_rd_vld_n;
   logic           w_err_out_n;

   logic           w_cmd_take;
   logic           w_d_bad;
   logic           w_unused_ok;

   assign app_rdy         = tilelink_reset_i && (r_state == S_IDLE);
   assign app_wdf_rdy     = tilelink_reset_i && !r_buf_full;
   assign tl_d_ready      = (r_state == S_RD_RESP) || (r_state == S_WR_RESP);
   assign app_rd_data_end = app_rd_data_valid;
   assign tl_a_param      = 3'd0;
   assign tl_a_corrupt    = 1'b0;

   assign w_cmd_take = app_en && app_rdy;
   assign w_buf_fill = app_wdf_wren && app_wdf_rdy;
   assign w_d_bad    = tl_d_denied || tl_d_corrupt;
   assign w_beat_inc = r_beat + 2'd1;
   // a write may be accepted in the same cycle its data arrives
   assign w_wdf_data = r_buf_full ? r_wdf_data : app_wdf_data;
   assign w_wdf_mask = r_buf_full ? r_wdf_mask : app_wdf_mask;

   assign w_unused_ok = &{1'b0, app_wdf_end, app_addr[3:0], tl_d_opcode,
                          tl_d_param, tl_d_size, tl_d_source};

   // next-state and next-output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_beat_nxt   = r_beat;
      w_err_nxt    = r_err;
      w_rd_buf_nxt = r_rd_buf;
      w_buf_free   = 1'b0;
      w_a_valid_n  = tl_a_valid;
      w_a_opcode_n = tl_a_opcode;
      w_a_size_n   = tl_a_size;
      w_a_source_n = tl_a_source;
      w_a_addr_n   = tl_a_address;
      w_a_mask_n   = tl_a_mask;
      w_a_data_n   = tl_a_data;
      w_rd_data_n  = app_rd_data;
      w_rd_vld_n   = 1'b0;
      w_err_out_n  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_take && (app_cmd == 3'd1 || app_cmd == 3'd0)) begin
               w_err_nxt    = 1'b0;
               w_beat_nxt   = 2'd0;
               w_a_addr_n   = {app_addr[27:4], 4'h0};
               w_a_size_n   = c_SIZE_16B;
               w_a_source_n = c_SRC;
               if (app_cmd == 3'd1) begin
                  w_state_nxt  = S_RD_REQ;
                  w_a_valid_n  = 1'b1;
                  w_a_opcode_n = c_OP_GET;
                  w_a_mask_n   = 4'hF;
                  w_a_data_n   = 32'h0;
               end else if (r_buf_full || w_buf_fill) begin
                  w_state_nxt  = S_WR_BEAT;
                  w_a_valid_n  = 1'b1;
                  w_a_opcode_n = (w_wdf_mask == 16'h0) ? c_OP_PUT_FULL : c_OP_PUT_PART;
                  w_a_mask_n   = ~w_wdf_mask[3:0];
                  w_a_data_n   = w_wdf_data[31:0];
               end else begin
                  w_state_nxt  = S_WR_WAIT;
               end
            end
         end
         S_RD_REQ: begin
            if (tl_a_ready) begin
               w_a_valid_n = 1'b0;
               w_state_nxt = S_RD_RESP;
            end
         end
         S_RD_RESP: begin
            if (tl_d_valid) begin
               if (r_beat == 2'd3) begin
                  w_state_nxt = S_IDLE;
                  w_rd_data_n = {tl_d_data, r_rd_buf};
                  w_rd_vld_n  = 1'b1;
                  w_err_out_n = r_err || w_d_bad;
                  w_err_nxt   = 1'b0;
               end else begin
                  case (r_beat)
                     2'd0:    w_rd_buf_nxt[31:0]  = tl_d_data;
                     2'd1:    w_rd_buf_nxt[63:32] = tl_d_data;
                     default: w_rd_buf_nxt[95:64] = tl_d_data;
                  endcase
                  w_beat_nxt = w_beat_inc;
                  w_err_nxt  = r_err || w_d_bad;
               end
            end
         end
         S_WR_WAIT: begin
            if (r_buf_full) begin
               w_state_nxt  = S_WR_BEAT;
               w_a_valid_n  = 1'b1;
               w_a_opcode_n = (r_wdf_mask == 16'h0) ? c_OP_PUT_FULL : c_OP_PUT_PART;
               w_a_mask_n   = ~r_wdf_mask[3:0];
               w_a_data_n   = r_wdf_data[31:0];
            end
         end
         S_WR_BEAT: begin
            if (tl_a_ready) begin
               if (r_beat == 2'd3) begin
                  w_a_valid_n = 1'b0;
                  w_buf_free  = 1'b1;
                  w_beat_nxt  = 2'd0;
                  w_state_nxt = S_WR_RESP;
               end else begin
                  w_beat_nxt = w_beat_inc;
                  w_a_mask_n = ~r_wdf_mask[{w_beat_inc, 2'b00} +: 4];
                  w_a_data_n = r_wdf_data[{w_beat_inc, 5'b00000} +: 32];
               end
            end
         end
         S_WR_RESP: begin
            if (tl_d_valid) begin
               w_state_nxt = S_IDLE;
               w_err_out_n = r_err || w_d_bad;
               w_err_nxt   = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state and registered outputs
   always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
      if (!tilelink_reset_i) begin
         r_state           <= S_IDLE;
         r_beat            <= 2'd0;
         r_err             <= 1'b0;
         r_rd_buf          <= '0;
         tl_a_valid        <= 1'b0;
         tl_a_opcode       <= '0;
         tl_a_size         <= '0;
         tl_a_source       <= '0;
         tl_a_address      <= '0;
         tl_a_mask         <= '0;
         tl_a_data         <= '0;
         app_rd_data       <= '0;
         app_rd_data_valid <= 1'b0;
         bridge_error_o    <= 1'b0;
      end else begin
         r_state           <= w_state_nxt;
         r_beat            <= w_beat_nxt;
         r_err             <= w_err_nxt;
         r_rd_buf          <= w_rd_buf_nxt;
         tl_a_valid        <= w_a_valid_n;
         tl_a_opcode       <= w_a_opcode_n;
         tl_a_size         <= w_a_size_n;
         tl_a_source       <= w_a_source_n;
         tl_a_address      <= w_a_addr_n;
         tl_a_mask         <= w_a_mask_n;
         tl_a_data         <= w_a_data_n;
         app_rd_data       <= w_rd_data_n;
         app_rd_data_valid <= w_rd_vld_n;
         bridge_error_o    <= w_err_out_n;
      end
   end

   // write-data buffer: filled by the UI, freed once the last Put beat is taken
   always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i) begin
      if (!tilelink_reset_i) begin
         r_buf_full <= 1'b0;
         r_wdf_data <= '0;
         r_wdf_mask <= '0;
      end else if (w_buf_free) begin
         r_buf_full <= 1'b0;
      end else if (w_buf_fill) begin
         r_buf_full <= 1'b1;
         r_wdf_data <= app_wdf_data;
         r_wdf_mask <= app_wdf_mask;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ui_to_tilelink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ui_to_tilelink
// Brief    : Directed bench for ui_to_tilelink with a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ui_to_tilelink;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] app_cmd = '0;  logic [27:0] app_addr = '0;  logic app_en = 1'b0;  logic app_rdy;
   logic [127:0] app_wdf_data = '0;  logic [15:0] app_wdf_mask = '0;
   logic app_wdf_wren = 1'b0, app_wdf_end = 1'b0, app_wdf_rdy;
   logic [127:0] app_rd_data;  logic app_rd_data_valid, app_rd_data_end;
   logic [2:0] tl_a_opcode, tl_a_param;  logic [3:0] tl_a_size, tl_a_source, tl_a_mask;
   logic [27:0] tl_a_address;  logic [31:0] tl_a_data;  logic tl_a_corrupt, tl_a_valid;
   logic tl_a_ready = 1'b1;
   logic [2:0] tl_d_opcode = '0;  logic [1:0] tl_d_param = '0;  logic [3:0] tl_d_size = 4'd2;
   logic [3:0] tl_d_source = '0;  logic tl_d_denied = 1'b0, tl_d_corrupt = 1'b0, tl_d_valid = 1'b0;
   logic [31:0] tl_d_data = '0;  logic tl_d_ready;  logic bridge_error_o;

   ui_to_tilelink #(.TL_RS(4), .SOURCE_ID(0)) dut (
      .tilelink_clock_i(clk), .tilelink_reset_i(rst_n),
      .app_cmd(app_cmd), .app_addr(app_addr), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
      .tl_a_opcode(tl_a_opcode), .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
      .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data), .tl_a_corrupt(tl_a_corrupt),
      .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready),
      .tl_d_opcode(tl_d_opcode), .tl_d_param(tl_d_param), .tl_d_size(tl_d_size), .tl_d_source(tl_d_source),
      .tl_d_denied(tl_d_denied), .tl_d_data(tl_d_data), .tl_d_corrupt(tl_d_corrupt),
      .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .bridge_error_o(bridge_error_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- model state ----------------
   typedef struct packed { logic [2:0] op; logic [27:0] addr; logic [3:0] mask; logic [31:0] data; } abeat_t;
   typedef struct packed { logic [127:0] data; logic err; } rd_t;
   typedef struct packed { logic [2:0] op; logic [31:0] data; logic den; logic cor; } dbeat_t;

   abeat_t exp_a[$];
   rd_t    exp_rd[$];
   dbeat_t d_q[$];
   abeat_t a_log[$];
   int     a_cyc[$];

   int n_checks = 0, n_fail = 0, n_done = 0, rd_pulses = 0;
   logic [127:0] last_rd = '0;  logic last_rd_err = 1'b0;  int last_rd_cyc = 0;
   logic last_wr_err = 1'b0;
   logic [3:0] rdy_pat = 4'b1111;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic exp_get(input logic [27:0] a);
      abeat_t b;
      b.op = 3'd4; b.addr = a & 28'hFFFFFF0; b.mask = 4'hF; b.data = 32'h0;
      exp_a.push_back(b);
   endtask

   task automatic exp_put(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
      abeat_t b;
      for (int k = 0; k < 4; k++) begin
         b.op   = (m == 16'h0) ? 3'd0 : 3'd1;
         b.addr = a & 28'hFFFFFF0;
         b.mask = ~m[4*k +: 4];
         b.data = d[32*k +: 32];
         exp_a.push_back(b);
      end
   endtask

   // queue four AccessAckData beats and the UI read result they must produce
   task automatic plan_read(input logic [127:0] d, input logic [3:0] den);
      dbeat_t e;  rd_t r;
      for (int k = 0; k < 4; k++) begin
         e.op = 3'd1; e.data = d[32*k +: 32]; e.den = den[k]; e.cor = 1'b0;
         d_q.push_back(e);
      end
      r.data = d; r.err = |den;
      exp_rd.push_back(r);
   endtask

   task automatic plan_ack(input logic den);
      dbeat_t e;
      e.op = 3'd0; e.data = 32'h0; e.den = den; e.cor = 1'b0;
      d_q.push_back(e);
   endtask

   task automatic send_cmd(input logic [2:0] c, input logic [27:0] a, output int acc);
      @(posedge clk); #1;
      app_cmd = c; app_addr = a; app_en = 1'b1; acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (app_rdy) begin acc = cyc; break; end
         @(posedge clk); #1;
      end
      if (acc < 0) chk("cmd_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      app_en = 1'b0;
   endtask

   task automatic send_wdf(input logic [127:0] d, input logic [15:0] m);
      bit ok;
      @(posedge clk); #1;
      app_wdf_data = d; app_wdf_mask = m; app_wdf_wren = 1'b1; app_wdf_end = 1'b1; ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (app_wdf_rdy) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) chk("wdf_accept_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 300; i++) begin
         if (n_done >= target) break;
         @(negedge clk);
      end
      if (n_done < target) chk("completion_timeout", n_done, target);
   endtask

   // A-channel ready pattern, one bit per cycle
   initial begin
      int idx = 0;
      forever begin
         @(posedge clk); #1;
         tl_a_ready = rdy_pat[idx];
         idx = (idx + 1) % 4;
      end
   end

   // D-channel responder: presents queued beats, pops each one that is accepted
   initial begin
      forever begin
         @(posedge clk); #1;
         if (d_q.size() > 0) begin
            tl_d_valid = 1'b1; tl_d_opcode = d_q[0].op; tl_d_data = d_q[0].data;
            tl_d_denied = d_q[0].den; tl_d_corrupt = d_q[0].cor;
         end else begin
            tl_d_valid = 1'b0; tl_d_denied = 1'b0; tl_d_corrupt = 1'b0; tl_d_data = '0;
         end
      end
   end
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tl_d_valid && tl_d_ready && d_q.size() > 0) void'(d_q.pop_front());
      end
   end

   // compare process: every cycle the outputs against the transaction model
   initial begin
      logic [79:0] cur_a, prev_a;
      bit prev_stall = 0, wr_done = 0, wr_err = 0, cur_read = 0, put_active = 0, post_put = 0;
      int put_beats = 0;
      abeat_t e;  rd_t r;
      prev_a = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 0; wr_done = 0; put_active = 0; put_beats = 0; post_put = 0;
         end else begin
            cur_a = {tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source,
                     tl_a_address, tl_a_mask, tl_a_data, tl_a_corrupt};
            if (prev_stall) chk("a_stable_while_stalled", cur_a, prev_a);
            prev_stall = tl_a_valid && !tl_a_ready;
            prev_a     = cur_a;
            if (post_put) chk("wdf_rdy_after_last_beat", app_wdf_rdy, 1'b1);
            post_put = 0;
            if (put_active) chk("app_rdy_low_during_write", app_rdy, 1'b0);
            if (tl_a_valid && tl_a_ready) begin
               if (exp_a.size() == 0) begin
                  chk("unexpected_a_beat", tl_a_address, 28'h0 - 28'h1);
               end else begin
                  e = exp_a.pop_front();
                  chk("a_opcode", tl_a_opcode, e.op);
                  chk("a_address", tl_a_address, e.addr);
                  chk("a_mask", tl_a_mask, e.mask);
                  chk("a_data", tl_a_data, e.data);
                  chk("a_size", tl_a_size, 4'd4);
                  chk("a_param_src_corrupt", {tl_a_param, tl_a_source, tl_a_corrupt}, 8'h0);
               end
               e.op = tl_a_opcode; e.addr = tl_a_address; e.mask = tl_a_mask; e.data = tl_a_data;
               a_log.push_back(e);
               a_cyc.push_back(cyc);
               cur_read = (tl_a_opcode == 3'd4);
               if (!cur_read) begin
                  chk("wdf_rdy_low_during_put", app_wdf_rdy, 1'b0);
                  put_active = 1;
                  put_beats++;
                  if (put_beats % 4 == 0) post_put = 1;
               end
            end
            if (app_rd_data_valid || app_rd_data_end)
               chk("rd_end_equals_valid", app_rd_data_end, app_rd_data_valid);
            if (app_rd_data_valid) begin
               n_done++; rd_pulses++;
               last_rd = app_rd_data; last_rd_err = bridge_error_o; last_rd_cyc = cyc;
               if (exp_rd.size() == 0) begin
                  chk("unexpected_rd_valid", app_rd_data_valid, 1'b0);
               end else begin
                  r = exp_rd.pop_front();
                  chk("rd_data", app_rd_data, r.data);
                  chk("rd_error_flag", bridge_error_o, r.err);
               end
            end else if (wr_done) begin
               n_done++;
               last_wr_err = bridge_error_o;
               chk("wr_error_flag", bridge_error_o, wr_err);
               chk("app_rdy_after_ack", app_rdy, 1'b1);
            end else if (bridge_error_o) begin
               chk("spurious_error_pulse", bridge_error_o, 1'b0);
            end
            wr_done = 0;
            if (tl_d_valid && tl_d_ready && !cur_read) begin
               wr_done = 1; wr_err = tl_d_denied || tl_d_corrupt; put_active = 0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int acc, n0, base_done, p0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_app_rdy", app_rdy, 1'b0);
      chk("reset_wdf_rdy", app_wdf_rdy, 1'b0);
      chk("reset_outputs", {tl_a_valid, tl_a_opcode, tl_a_mask, tl_a_data, app_rd_data_valid, bridge_error_o}, '0);
      chk("reset_rd_data", app_rd_data, '0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_rdys", {app_rdy, app_wdf_rdy}, 2'b11);

      // 1: best-case read
      plan_read(128'h44444444_33333333_22222222_11111111, 4'b0000);
      exp_get(28'h0000127);
      send_cmd(3'd1, 28'h0000127, acc);
      wait_done(1);
      repeat (3) @(negedge clk);
      chk("t1_rd_literal", last_rd, 128'h44444444_33333333_22222222_11111111);
      chk("t1_single_pulse", rd_pulses, 1);
      chk("t1_get_addr", a_log[a_log.size()-1].addr, 28'h0000120);
      chk("t1_latency", last_rd_cyc - acc, 6);
      chk("t1_no_err", last_rd_err, 1'b0);

      // 2: full write, data and command in the same cycle
      exp_put(28'h0000340, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'h0000);
      plan_ack(1'b0);
      n0 = a_log.size();
      @(posedge clk); #1;
      app_cmd = 3'd0; app_addr = 28'h0000340; app_en = 1'b1;
      app_wdf_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; app_wdf_mask = 16'h0; app_wdf_wren = 1'b1;
      @(negedge clk);
      chk("t2_both_ready", {app_rdy, app_wdf_rdy}, 2'b11);
      acc = cyc;
      @(posedge clk); #1; app_en = 1'b0; app_wdf_wren = 1'b0;
      wait_done(2);
      chk("t2_beat0_data", a_log[n0].data, 32'hAAAAAAAA);
      chk("t2_beat3_data", a_log[n0+3].data, 32'hDDDDDDDD);
      chk("t2_full_opcode", a_log[n0+2].op, 3'd0);
      chk("t2_first_beat_cycle", a_cyc[n0] - acc, 1);
      chk("t2_last_beat_cycle", a_cyc[n0+3] - acc, 4);

      // 3: partial write, command before data, denied AccessAck
      exp_put(28'h0000560, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFF0);
      plan_ack(1'b1);
      n0 = a_log.size();
      send_cmd(3'd0, 28'h0000560, acc);
      repeat (2) @(posedge clk);
      send_wdf(128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFF0);
      wait_done(3);
      chk("t3_partial_opcode", a_log[n0].op, 3'd1);
      chk("t3_beat_masks", {a_log[n0].mask, a_log[n0+1].mask, a_log[n0+2].mask, a_log[n0+3].mask}, 16'hF000);
      chk("t3_ack_error", last_wr_err, 1'b1);

      // 4: data three cycles ahead, stalling A channel
      exp_put(28'h0000780, 128'h89ABCDEF_01234567_FEDCBA98_76543210, 16'h0F00);
      plan_ack(1'b0);
      n0 = a_log.size();
      send_wdf(128'h89ABCDEF_01234567_FEDCBA98_76543210, 16'h0F00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t4_buffer_full", app_wdf_rdy, 1'b0);
      rdy_pat = 4'b1001;
      send_cmd(3'd0, 28'h0000789, acc);
      wait_done(4);
      rdy_pat = 4'b1111;
      chk("t4_beat_count", a_log.size() - n0, 4);
      chk("t4_beat2_mask", a_log[n0+2].mask, 4'h0);
      chk("t4_err_cleared", last_wr_err, 1'b0);

      // 5: read with denied on beat 2
      plan_read(128'hCAFEF00D_DEADBEEF_5A5A5A5A_A5A5A5A5, 4'b0100);
      exp_get(28'h0ABCDE0);
      send_cmd(3'd1, 28'h0ABCDEF, acc);
      wait_done(5);
      chk("t5_rd_literal", last_rd, 128'hCAFEF00D_DEADBEEF_5A5A5A5A_A5A5A5A5);
      chk("t5_err_with_valid", last_rd_err, 1'b1);

      // no-op command: accepted, no traffic
      n0 = a_log.size();
      send_cmd(3'd2, 28'h0000100, acc);
      repeat (5) @(negedge clk);
      chk("noop_no_traffic", a_log.size() - n0, 0);
      chk("noop_rdy", app_rdy, 1'b1);

      // 6: reset after the second D beat of a read
      begin
         dbeat_t e;
         e.op = 3'd1; e.den = 1'b0; e.cor = 1'b0;
         e.data = 32'h01010101; d_q.push_back(e);
         e.data = 32'h02020202; d_q.push_back(e);
      end
      exp_get(28'h0000200);
      p0 = rd_pulses;
      base_done = n_done;
      send_cmd(3'd1, 28'h0000200, acc);
      for (int i = 0; i < 100 && d_q.size() > 0; i++) @(negedge clk);
      @(posedge clk); #1; rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_app_rdy", app_rdy, 1'b0);
      chk("rst_mid_outputs", {tl_a_valid, app_rd_data_valid, bridge_error_o, app_wdf_rdy}, 4'h0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_app_rdy", app_rdy, 1'b1);
      repeat (8) @(negedge clk);
      chk("rst_no_completion", rd_pulses - p0, 0);

      // 7: fresh read after the abandoned one
      plan_read(128'h13579BDF_2468ACE0_FFFF0000_0000FFFF, 4'b0000);
      exp_get(28'h0000440);
      send_cmd(3'd1, 28'h0000440, acc);
      wait_done(base_done + 1);
      chk("t7_rd_literal", last_rd, 128'h13579BDF_2468ACE0_FFFF0000_0000FFFF);

      repeat (4) @(negedge clk);
      chk("end_exp_a_empty", exp_a.size(), 0);
      chk("end_exp_rd_empty", exp_rd.size(), 0);
      chk("end_d_q_empty", d_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ui_to_tilelink.md
# ui_to_tilelink

Bridge that exposes a Xilinx-MIG-style UI slave port (app_cmd/app_en, write-data FIFO, read-data return) and converts each 128-bit UI command into TileLink-UL master transactions on a 32-bit TL bus. UI-native clients, such as DMA engines or memory testers written against the DDR3 UI, use it to reach any TileLink slave, including the DDR3 controller behind the TL-to-UI bridge. One transaction is outstanding at a time.

## Interface
- TL_RS, 4, TileLink source width
- SOURCE_ID, 0, value driven on tl_a_source

Ports:
- tilelink_clock_i  in  1  sole clock; all logic on rising edge
- tilelink_reset_i  in  1  asynchronous, active-low reset
- app_cmd  in  3  UI command: 1 = read, 0 = write, others = no-op
- app_addr  in  28  byte address; bits [3:0] ignored
- app_en  in  1  command valid
- app_rdy  out  1  command ready
- app_wdf_data  in  128  write data
- app_wdf_mask  in  16  per-byte mask; 1 = byte NOT written
- app_wdf_wren  in  1  write data valid
- app_wdf_end  in  1  accepted, ignored (always single-beat)
- app_wdf_rdy  out  1  write-data ready
- app_rd_data  out  128  read data
- app_rd_data_valid  out  1  read data valid, one-cycle pulse, no backpressure
- app_rd_data_end  out  1  equals app_rd_data_valid
- tl_a_opcode/param/size/source/address/mask/data/corrupt  out  3/3/4/TL_RS/28/4/32/1  TL A channel
- tl_a_valid  out  1;  tl_a_ready  in  1
- tl_d_opcode/param/size/source/denied/data/corrupt  in  3/2/4/TL_RS/1/32/1  TL D channel
- tl_d_valid  in  1;  tl_d_ready  out  1
- bridge_error_o  out  1  one-cycle pulse at completion if any D beat had denied or corrupt set

## Operation
- States: IDLE, RD_REQ, RD_RESP, WR_WAIT, WR_BEAT, WR_RESP.
- app_rdy = (state == IDLE). A command is taken when app_en && app_rdy. The address is latched as {app_addr[27:4], 4'h0}.
- Write buffer: one 128-bit entry with a mask, independent of the FSM. app_wdf_rdy = buffer empty. It fills on app_wdf_wren && app_wdf_rdy and may fill before, with or after the write command, and during a read.
- Read command: IDLE -> RD_REQ.
  - Drive Get: opcode 4, param 0, size 4, mask 4'hF, data 0, corrupt 0.
  - On tl_a_ready -> RD_RESP.
  - In RD_RESP, tl_d_ready = 1. A 2-bit beat counter places D beat k into rd_buf[32k+31:32k].
  - On acceptance of the 4th beat -> IDLE, with app_rd_data = rd_buf and app_rd_data_valid = app_rd_data_end = 1 on the next cycle.
- Write command:
  - IDLE -> WR_BEAT if the buffer is full or filling this cycle, else WR_WAIT.
  - WR_WAIT -> WR_BEAT when the buffer is full.
  - WR_BEAT issues 4 A beats, size 4, on the same address. Opcode is 0 (PutFullData) if the buffered mask == 16'h0000, else 1 (PutPartialData).
  - Beat k carries data wdf[32k+31:32k] and mask ~wdf_mask[4k+3:4k].
  - The beat counter advances on tl_a_valid && tl_a_ready. After beat 3 is accepted, the buffer is freed and the state goes to WR_RESP.
  - In WR_RESP, tl_d_ready = 1. One AccessAck -> IDLE.
- Other cmd values: accepted and dropped, no TL traffic, FSM stays in IDLE.
- Error flag: set by tl_d_denied or tl_d_corrupt on any accepted D beat, cleared on entry to IDLE. bridge_error_o pulses alongside the completion: the read-data pulse, or the cycle after the AccessAck.
- Read data is delivered even when denied or corrupt.
- tl_d_ready = 0 in IDLE, RD_REQ, WR_WAIT and WR_BEAT, so no D beat is accepted in those states.
- Reset (asserted):
  - State IDLE, write buffer empty.
  - All registered outputs 0: tl_a_valid, tl_a_* fields, app_rd_data, app_rd_data_valid, app_rd_data_end, bridge_error_o.
  - app_rdy and app_wdf_rdy forced 0 while reset is asserted; both are 1 from the first cycle after deassertion.
  - Reset mid-transaction abandons it: no completion pulse, no further A beats.

## Timing
- Command accepted in cycle N -> tl_a_valid high in N+1 (registered).
- A-channel fields are stable while tl_a_valid && !tl_a_ready. tl_a_valid never drops without a handshake.
- Write beats run back-to-back when tl_a_ready is held high: beats in N+1..N+4, tl_a_valid low in N+5.
- Read, best case: Get accepted in N+1. D beats in N+2..N+5 if tl_d_valid is high. app_rd_data_valid and app_rdy both high in N+6.
- Write completion: AccessAck accepted in cycle M -> app_rdy high in M+1.
- Back-to-back commands: the next command can be accepted in the first IDLE cycle.
- The write buffer refills while the previous write is waiting in WR_RESP.

## Test plan
- Read, app_addr = 0x0000127; D beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> one Get with address 0x0000120, size 4, mask F. Then app_rd_data = 0x44444444_33333333_22222222_11111111, valid for exactly 1 cycle, bridge_error_o = 0.
- Write to 0x0000340, mask 16'h0000, data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> 4 beats with opcode 0, mask F each, data AAAA.., BBBB.., CCCC.., DDDD... app_rdy is low until the AccessAck is accepted.
- Partial write with mask 16'hFFF0 -> opcode 1; beat masks F, 0, 0, 0.
- Write data presented 3 cycles before the command, with tl_a_ready toggling 1, 0, 0, 1 -> A fields are held stable while stalled, 4 beats total, buffer freed after beat 3.
- Read where tl_d_denied = 1 on beat 2 -> rd_data is still delivered, and bridge_error_o pulses in the same cycle as app_rd_data_valid.
- Assert reset after the second D beat of a read -> no app_rd_data_valid. app_rdy = 1 the first cycle after release, and a new read completes normally.
